// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC lane training controller.
// State encoding, lane slice helpers and the eye-centre arithmetic.
package adc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CAL,
    ST_CALWAIT,
    ST_SETTLE,
    ST_CHECK,
    ST_SCAN,
    ST_CENTER,
    ST_SLIPCHK,
    ST_NEXT
  } state_t;

  typedef enum logic {
    PH_SCAN,
    PH_SLIP
  } phase_t;

  localparam int CAL_TIMEOUT = 1024;
  localparam int TAP_W       = 8;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // floor((a + b) / 2) on a 9-bit sum so e = TAPMAX+1 cannot wrap
  function automatic logic [7:0] mid(
    input logic [7:0] a,
    input logic [8:0] b
  );
    logic [8:0] sum;
    sum = {1'b0, a} + b;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/adc_word_check.sv
// Word stability / pattern comparator for the lane under training.
// Latches the first word on start, compares the next CHECK-1 words.
module adc_word_check
  import adc_pkg::*;
#(
  parameter int               WIDTH   = 6,
  parameter int               CHECK   = 16,
  parameter logic [WIDTH-1:0] PATTERN = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             done,
  output logic             stable,
  output logic             match
);

  localparam logic [7:0] CNT_LAST = 8'(CHECK - 1);

  logic [WIDTH-1:0] ref_word;
  logic [7:0]       cnt;
  logic             active;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_word <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      stable   <= 1'b0;
      match    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        ref_word <= word;
        cnt      <= 8'd1;
        active   <= 1'b1;
        stable   <= 1'b1;
        match    <= (word == PATTERN);
      end else if (active) begin
        if (word != ref_word) stable <= 1'b0;
        cnt <= cnt + 8'd1;
        if (cnt == CNT_LAST) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_lane_align.sv
// ADC DDR lane training: IODELAY2 calibration, tap scan, eye centring
// and ISERDES2 bitslip word alignment, one lane at a time.
module adc_lane_align
  import adc_pkg::*;
#(
  parameter int               NLANES  = 2,
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b111000,
  parameter int               TAPMAX  = 63,
  parameter int               SETTLE  = 8,
  parameter int               CHECK   = 16,
  parameter int               MINEYE  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [NLANES*WIDTH-1:0] DATA,
  input  logic [NLANES-1:0]       IOD_BUSY,
  output logic [NLANES-1:0]       DCAL,
  output logic [NLANES-1:0]       DRST,
  output logic [NLANES-1:0]       DCE,
  output logic [NLANES-1:0]       DINC,
  output logic [NLANES-1:0]       BS,
  output logic                    SRST,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [NLANES-1:0]       LANE_OK,
  output logic [NLANES*8-1:0]     TAP
);

  localparam int LW = lane_w(NLANES);

  localparam logic [LW-1:0] LANE_LAST  = LW'(NLANES - 1);
  localparam logic [7:0]    TAP_LAST   = 8'(TAPMAX);
  localparam logic [8:0]    TAP_END    = 9'(TAPMAX + 1);
  localparam logic [8:0]    MINEYE9    = 9'(MINEYE);
  localparam logic [15:0]   SET_LAST   = 16'(SETTLE - 1);
  localparam logic [10:0]   CAL_LAST   = 11'(CAL_TIMEOUT - 1);
  localparam logic [3:0]    SLIP_LAST  = 4'(WIDTH - 1);

  state_t          state;
  phase_t          phase;
  logic [LW-1:0]   lane;
  logic [7:0]      tap;
  logic [7:0]      s_tap;
  logic [7:0]      c_tap;
  logic [8:0]      run_len;
  logic [3:0]      slips;
  logic [15:0]     scnt;
  logic [10:0]     wcnt;
  logic            seen_busy;
  logic            chk_start;

  logic [WIDTH-1:0] lane_words [NLANES];
  logic [WIDTH-1:0] word;
  logic             iod_busy;
  logic             chk_done;
  logic             chk_stable;
  logic             chk_match;
  logic [7:0]       s_nxt;
  logic [8:0]       run_nxt;
  logic [LW+2:0]    tap_base;

  for (genvar g = 0; g < NLANES; g++) begin : g_mux
    assign lane_words[g] = DATA[g*WIDTH +: WIDTH];
  end

  assign word     = lane_words[lane];
  assign iod_busy = IOD_BUSY[lane];
  assign tap_base = {lane, 3'b000};
  assign s_nxt    = (run_len == 9'd0) ? tap : s_tap;
  assign run_nxt  = run_len + 9'd1;

  adc_word_check #(
    .WIDTH  (WIDTH),
    .CHECK  (CHECK),
    .PATTERN(PATTERN)
  ) u_check (
    .clk   (CLK),
    .rst   (RST),
    .start (chk_start),
    .word  (word),
    .done  (chk_done),
    .stable(chk_stable),
    .match (chk_match)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      phase     <= PH_SCAN;
      lane      <= '0;
      tap       <= '0;
      s_tap     <= '0;
      c_tap     <= '0;
      run_len   <= '0;
      slips     <= '0;
      scnt      <= '0;
      wcnt      <= '0;
      seen_busy <= 1'b0;
      chk_start <= 1'b0;
      DCAL      <= '0;
      DRST      <= '0;
      DCE       <= '0;
      DINC      <= '0;
      BS        <= '0;
      SRST      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      LANE_OK   <= '0;
      TAP       <= '0;
    end else begin
      DCAL      <= '0;
      DRST      <= '0;
      DCE       <= '0;
      DINC      <= '0;
      BS        <= '0;
      SRST      <= 1'b0;
      chk_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            SRST    <= 1'b1;
            DONE    <= 1'b0;
            LANE_OK <= '0;
            TAP     <= '0;
            BUSY    <= 1'b1;
            lane    <= '0;
            state   <= ST_CAL;
          end
        end
        ST_CAL: begin
          DCAL[lane] <= 1'b1;
          tap        <= '0;
          wcnt       <= '0;
          seen_busy  <= 1'b0;
          state      <= ST_CALWAIT;
        end
        ST_CALWAIT: begin
          wcnt <= wcnt + 11'd1;
          if (iod_busy) seen_busy <= 1'b1;
          if (seen_busy && !iod_busy) begin
            DRST[lane] <= 1'b1;
            tap        <= '0;
            phase      <= PH_SCAN;
            run_len    <= '0;
            s_tap      <= '0;
            scnt       <= '0;
            state      <= ST_SETTLE;
          end else if (wcnt == CAL_LAST) begin
            TAP[tap_base +: 8] <= tap;
            state              <= ST_NEXT;
          end
        end
        ST_SETTLE: begin
          if (scnt == SET_LAST) begin
            scnt      <= '0;
            chk_start <= 1'b1;
            state     <= ST_CHECK;
          end else begin
            scnt <= scnt + 16'd1;
          end
        end
        ST_CHECK: begin
          if (chk_done)
            state <= (phase == PH_SCAN) ? ST_SCAN : ST_SLIPCHK;
        end
        ST_SCAN: begin
          if (chk_stable) begin
            s_tap   <= s_nxt;
            run_len <= run_nxt;
          end else begin
            run_len <= '0;
          end
          if (!chk_stable && run_len >= MINEYE9) begin
            c_tap <= mid(s_tap, {1'b0, tap});
            scnt  <= '0;
            state <= ST_CENTER;
          end else if (tap == TAP_LAST) begin
            if (chk_stable && run_nxt >= MINEYE9) begin
              c_tap <= mid(s_nxt, TAP_END);
              scnt  <= '0;
              state <= ST_CENTER;
            end else begin
              TAP[tap_base +: 8] <= tap;
              state              <= ST_NEXT;
            end
          end else begin
            DCE[lane]  <= 1'b1;
            DINC[lane] <= 1'b1;
            tap        <= tap + 8'd1;
            scnt       <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_CENTER: begin
          if (tap == c_tap) begin
            phase <= PH_SLIP;
            slips <= '0;
            scnt  <= '0;
            state <= ST_SETTLE;
          end else begin
            // one decrement per SETTLE cycles, first one immediately
            if (scnt == 16'd0) begin
              DCE[lane] <= 1'b1;
              tap       <= tap - 8'd1;
            end
            scnt <= (scnt == SET_LAST) ? 16'd0 : scnt + 16'd1;
          end
        end
        ST_SLIPCHK: begin
          if (chk_stable && chk_match) begin
            LANE_OK[lane]      <= 1'b1;
            TAP[tap_base +: 8] <= c_tap;
            state              <= ST_NEXT;
          end else if (slips == SLIP_LAST) begin
            TAP[tap_base +: 8] <= tap;
            state              <= ST_NEXT;
          end else begin
            BS[lane] <= 1'b1;
            slips    <= slips + 4'd1;
            scnt     <= '0;
            state    <= ST_SETTLE;
          end
        end
        ST_NEXT: begin
          if (lane == LANE_LAST) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            lane  <= lane + 1'b1;
            state <= ST_CAL;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_lane_align.sv
// Self-checking bench for adc_lane_align with a behavioural
// IODELAY2/ISERDES2 lane model and a per-lane result scoreboard.
module tb_adc_lane_align;

  localparam int NL = 2;
  localparam int W  = 6;
  localparam logic [W-1:0] PAT   = 6'b111000;
  localparam logic [W-1:0] NOPAT = 6'b101010;
  localparam int LIMIT = 20000;

  logic            CLK = 1'b0;
  logic            RST;
  logic            START;
  logic [NL*W-1:0] DATA;
  logic [NL-1:0]   IOD_BUSY;
  logic [NL-1:0]   DCAL, DRST, DCE, DINC, BS, LANE_OK;
  logic            SRST, BUSY, DONE;
  logic [NL*8-1:0] TAP;

  always #5 CLK = ~CLK;

  adc_lane_align #(
    .NLANES (NL),
    .WIDTH  (W),
    .PATTERN(PAT),
    .TAPMAX (63),
    .SETTLE (8),
    .CHECK  (16),
    .MINEYE (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .DATA    (DATA),
    .IOD_BUSY(IOD_BUSY),
    .DCAL    (DCAL),
    .DRST    (DRST),
    .DCE     (DCE),
    .DINC    (DINC),
    .BS      (BS),
    .SRST    (SRST),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .LANE_OK (LANE_OK),
    .TAP     (TAP)
  );

  typedef struct {
    int   lane;
    logic ok;
    int   tap;
    int   inc;
    int   dec;
    int   bs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         m_tap  [NL];
  int         m_slip [NL];
  int         cal_cnt[NL];
  int         n_inc  [NL];
  int         n_dec  [NL];
  int         n_bs   [NL];
  int         n_srst;
  int         lo0[NL], hi0[NL], lo1[NL], hi1[NL], rot0[NL];
  logic [W-1:0] base[NL];
  string      fld[5] = '{"lane_ok", "tap", "inc", "dec", "bs"};

  function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int k);
    logic [W-1:0] r;
    r = w;
    for (int i = 0; i < k % W; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  function automatic bit in_eye(input int l, input int t);
    return (t >= lo0[l] && t <= hi0[l]) || (t >= lo1[l] && t <= hi1[l]);
  endfunction

  // Lane model: delay line, bitslip, CAL busy handshake, data eye.
  always @(negedge CLK) begin
    if (SRST === 1'b1) begin
      n_srst++;
      for (int l = 0; l < NL; l++) m_slip[l] = 0;
    end
    for (int l = 0; l < NL; l++) begin
      if (DCAL[l] === 1'b1) cal_cnt[l] = 6;
      else if (cal_cnt[l] > 0) cal_cnt[l]--;
      if (DRST[l] === 1'b1) m_tap[l] = 0;
      if (DCE[l] === 1'b1) begin
        if (DINC[l]) begin m_tap[l]++; n_inc[l]++; end
        else begin m_tap[l]--; n_dec[l]++; end
      end
      if (BS[l] === 1'b1) begin
        m_slip[l] = (m_slip[l] + 1) % W;
        n_bs[l]++;
      end
      IOD_BUSY[l] = (cal_cnt[l] >= 1 && cal_cnt[l] <= 4);
      DATA[l*W +: W] = in_eye(l, m_tap[l]) ?
        rotl(base[l], rot0[l] + m_slip[l]) : W'($urandom);
    end
  end

  task automatic set_lane(input int l, input int a0, input int b0,
                          input int a1, input int b1, input int r,
                          input logic [W-1:0] b);
    lo0[l] = a0; hi0[l] = b0; lo1[l] = a1; hi1[l] = b1;
    rot0[l] = r; base[l] = b;
  endtask

  task automatic push_exp(input int l, input logic ok, input int tp,
                          input int inc, input int dec, input int bs);
    exp_t e;
    e.lane = l; e.ok = ok; e.tap = tp; e.inc = inc; e.dec = dec; e.bs = bs;
    sb.push_back(e);
  endtask

  task automatic clr_counts();
    n_srst = 0;
    for (int l = 0; l < NL; l++) begin
      n_inc[l] = 0; n_dec[l] = 0; n_bs[l] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    int cyc;
    cyc = 0;
    while (DONE !== 1'b1 && cyc < LIMIT) begin
      @(negedge CLK);
      cyc++;
    end
    timed_out = (DONE !== 1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if ({DCAL, DRST, DCE, DINC, BS, SRST, BUSY, DONE, LANE_OK, TAP} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {DCAL, DRST, DCE, DINC, BS, SRST, BUSY, DONE, LANE_OK, TAP});
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b done %b required 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_basic();
    bit to;
    exp_t e;
    integer got[5], want[5];
    set_lane(0, 10, 30, 1, 0, 2, PAT);
    set_lane(1, 0, 63, 1, 0, 0, PAT);
    push_exp(0, 1'b1, 20, 31, 11, 4);
    push_exp(1, 1'b1, 32, 63, 31, 0);
    clr_counts();
    pulse_start();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL basic.busy: got %b required 1", BUSY);
    end
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic.done_timeout: done %b required 1", DONE);
    end
    checks++;
    if (BUSY !== 1'b0 || n_srst != 1) begin
      errors++;
      $display("FAIL basic.end: busy %b srst %0d required 0 1", BUSY, n_srst);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got  = '{LANE_OK[e.lane], TAP[e.lane*8 +: 8], n_inc[e.lane], n_dec[e.lane], n_bs[e.lane]};
      want = '{e.ok, e.tap, e.inc, e.dec, e.bs};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL basic.%s lane %0d: got %0d required %0d", fld[k], e.lane, got[k], want[k]);
        end
      end
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL basic.done_sticky: got %b required 1", DONE);
    end
  endtask

  task automatic test_short_run();
    bit to;
    exp_t e;
    integer got[5], want[5];
    set_lane(0, 5, 7, 40, 50, 0, PAT);
    set_lane(1, 20, 23, 1, 0, 1, PAT);
    push_exp(0, 1'b1, 45, 51, 6, 0);
    push_exp(1, 1'b1, 22, 24, 2, 5);
    clr_counts();
    pulse_start();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL short.done_timeout: done %b required 1", DONE);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got  = '{LANE_OK[e.lane], TAP[e.lane*8 +: 8], n_inc[e.lane], n_dec[e.lane], n_bs[e.lane]};
      want = '{e.ok, e.tap, e.inc, e.dec, e.bs};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL short.%s lane %0d: got %0d required %0d", fld[k], e.lane, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_fail_lanes();
    bit to;
    exp_t e;
    integer got[5], want[5];
    set_lane(0, 1, 0, 1, 0, 0, PAT);
    set_lane(1, 10, 30, 1, 0, 0, NOPAT);
    push_exp(0, 1'b0, 63, 63, 0, 0);
    push_exp(1, 1'b0, 20, 31, 11, 5);
    clr_counts();
    pulse_start();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL fail.done_timeout: done %b required 1", DONE);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got  = '{LANE_OK[e.lane], TAP[e.lane*8 +: 8], n_inc[e.lane], n_dec[e.lane], n_bs[e.lane]};
      want = '{e.ok, e.tap, e.inc, e.dec, e.bs};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL fail.%s lane %0d: got %0d required %0d", fld[k], e.lane, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int cyc;
    exp_t e;
    integer got[5], want[5];
    set_lane(0, 10, 30, 1, 0, 2, PAT);
    set_lane(1, 0, 63, 1, 0, 0, PAT);
    clr_counts();
    pulse_start();
    cyc = 0;
    while (n_inc[1] < 5 && cyc < LIMIT) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (n_inc[1] < 5) begin
      errors++;
      $display("FAIL mid.reach_scan: lane1 inc %0d required >= 5", n_inc[1]);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({DCAL, DRST, DCE, DINC, BS, SRST, BUSY, DONE, LANE_OK, TAP} !== '0) begin
      errors++;
      $display("FAIL mid.reset_outputs: got %h required 0",
               {DCAL, DRST, DCE, DINC, BS, SRST, BUSY, DONE, LANE_OK, TAP});
    end
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    push_exp(0, 1'b1, 20, 31, 11, 4);
    push_exp(1, 1'b1, 32, 63, 31, 0);
    clr_counts();
    pulse_start();
    repeat (50) @(negedge CLK);
    pulse_start();
    wait_done(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL mid.done_timeout: done %b required 1", DONE);
    end
    checks++;
    if (n_srst != 1) begin
      errors++;
      $display("FAIL mid.start_while_busy: srst pulses %0d required 1", n_srst);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got  = '{LANE_OK[e.lane], TAP[e.lane*8 +: 8], n_inc[e.lane], n_dec[e.lane], n_bs[e.lane]};
      want = '{e.ok, e.tap, e.inc, e.dec, e.bs};
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL mid.%s lane %0d: got %0d required %0d", fld[k], e.lane, got[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    DATA = '0;
    IOD_BUSY = '0;
    for (int l = 0; l < NL; l++) begin
      m_tap[l] = 0; m_slip[l] = 0; cal_cnt[l] = 0;
      set_lane(l, 1, 0, 1, 0, 0, PAT);
    end
    clr_counts();
    test_reset();
    test_basic();
    test_short_run();
    test_fail_lanes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
